// File: rtl/rng_sched_if.sv
// Bus between rng_sched, its seed/requester clients and the shared rng core.
// master = clients and rng side, slave = the scheduler.
interface rng_sched_if #(
    parameter int NREQ = 4
);
    logic            seed_req_i;
    logic [31:0]     seed_i;
    logic            seed_ack_o;
    logic            rng_loadseed_o;
    logic [31:0]     rng_seed_o;
    logic [31:0]     rng_number_i;
    logic [NREQ-1:0] req_i;
    logic [NREQ-1:0] gnt_o;
    logic            valid_o;
    logic [31:0]     number_o;
    logic            busy_o;
    logic            stuck_o;

    modport master (
        output seed_req_i, seed_i, rng_number_i, req_i,
        input  seed_ack_o, rng_loadseed_o, rng_seed_o, gnt_o, valid_o,
               number_o, busy_o, stuck_o
    );

    modport slave (
        input  seed_req_i, seed_i, rng_number_i, req_i,
        output seed_ack_o, rng_loadseed_o, rng_seed_o, gnt_o, valid_o,
               number_o, busy_o, stuck_o
    );
endinterface

// File: rtl/rng_sched.sv
// Round-robin scheduler sharing one rng among NREQ requesters, with seed load and warm-up.
// Optional repeated-word detector enabled by defining RNG_REPEAT_CHK_EN.
module rng_sched #(
    parameter int NREQ   = 4,
    parameter int WARMUP = 8,
    parameter int CW     = 5
) (
    input  logic        clk,
    input  logic        reset,
    rng_sched_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {WARM, SERVE, LOAD} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            valid_q, valid_d;
    logic [31:0]     num_q, num_d;
    logic            ack_q, ack_d;
    logic            load_q, load_d;
    logic [31:0]     seed_q, seed_d;
    logic            sel_found;
    logic [PW-1:0]   sel;

    // Round-robin search starting just above the last winner.
    always_comb begin
        int idx;
        sel_found = 1'b0;
        sel       = ptr_q;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!sel_found && bus.req_i[idx[PW-1:0]]) begin
                sel_found = 1'b1;
                sel       = idx[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WARM;
            cnt_q   <= CW'(WARMUP - 1);
            ptr_q   <= PW'(NREQ - 1);
            gnt_q   <= '0;
            valid_q <= 1'b0;
            num_q   <= '0;
            ack_q   <= 1'b0;
            load_q  <= 1'b0;
            seed_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            num_q   <= num_d;
            ack_q   <= ack_d;
            load_q  <= load_d;
            seed_q  <= seed_d;
        end
    end

    // A seed request raised during warm-up waits until the counter expires.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WARM: begin
                if (cnt_q == '0) state_d = bus.seed_req_i ? LOAD : SERVE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            SERVE: begin
                if (bus.seed_req_i) state_d = LOAD;
            end
            LOAD: begin
                state_d = WARM;
                cnt_d   = CW'(WARMUP - 1);
            end
            default: begin
                state_d = WARM;
                cnt_d   = CW'(WARMUP - 1);
            end
        endcase
    end

    // Registered outputs: LOAD lasts one cycle, so the seed pulses are one cycle wide.
    always_comb begin
        gnt_d   = '0;
        valid_d = 1'b0;
        num_d   = num_q;
        ptr_d   = ptr_q;
        ack_d   = 1'b0;
        load_d  = 1'b0;
        seed_d  = seed_q;
        if (state_q == SERVE && !bus.seed_req_i && sel_found) begin
            gnt_d   = NREQ'(1) << sel;
            valid_d = 1'b1;
            num_d   = bus.rng_number_i;
            ptr_d   = sel;
        end
        if (state_d == LOAD) begin
            ack_d  = 1'b1;
            load_d = 1'b1;
            seed_d = bus.seed_i;
        end
    end

    assign bus.gnt_o          = gnt_q;
    assign bus.valid_o        = valid_q;
    assign bus.number_o       = num_q;
    assign bus.seed_ack_o     = ack_q;
    assign bus.rng_loadseed_o = load_q;
    assign bus.rng_seed_o     = seed_q;
    assign bus.busy_o         = (state_q != SERVE);

`ifdef RNG_REPEAT_CHK_EN
    logic [31:0] prev_q;
    logic        pvld_q, pvld_d;
    logic        match_q, match_d;
    logic        stuck_q, stuck_d;
    logic        match;

    assign match = pvld_q && (bus.rng_number_i == prev_q);

    always_ff @(posedge clk) begin
        if (state_q == SERVE) prev_q <= bus.rng_number_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pvld_q  <= 1'b0;
            match_q <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            pvld_q  <= pvld_d;
            match_q <= match_d;
            stuck_q <= stuck_d;
        end
    end

    // Stuck needs two back-to-back matches, i.e. three identical SERVE words.
    always_comb begin
        pvld_d  = 1'b0;
        match_d = 1'b0;
        stuck_d = stuck_q;
        if (state_q == SERVE) begin
            pvld_d  = 1'b1;
            match_d = match;
            stuck_d = stuck_q | (match & match_q);
        end
        if (state_d == LOAD) stuck_d = 1'b0;
    end

    assign bus.stuck_o = stuck_q;
`else
    assign bus.stuck_o = 1'b0;
`endif
endmodule

// File: tb/tb_rng_sched.sv
// Directed-plus-random bench for rng_sched against a cycle-level behavioural model.
module tb_rng_sched;
    localparam int NREQ   = 4;
    localparam int WARMUP = 8;
`ifdef RNG_REPEAT_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int P_WARM = 0, P_SERVE = 1, P_LOAD = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rng_sched_if #(.NREQ(NREQ)) bus ();
    rng_sched #(.NREQ(NREQ), .WARMUP(WARMUP), .CW(5)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int          m_phase, warm_left, last_win, run;
    logic [31:0] run_word;
    logic [3:0]  e_gnt;
    logic        e_valid, e_ack, e_load, e_busy, e_stuck;
    logic [31:0] e_num, e_seed;
    bit          fix_rng = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [3:0] req);
        for (int k = 1; k <= NREQ; k++)
            if (req[(last + k) % NREQ]) return (last + k) % NREQ;
        return last;
    endfunction

    task automatic model_reset();
        m_phase = P_WARM; warm_left = WARMUP; last_win = NREQ - 1; run = 0;
        run_word = '0;
        e_gnt = '0; e_valid = 0; e_num = '0; e_ack = 0; e_load = 0;
        e_seed = '0; e_busy = 1; e_stuck = 0;
    endtask

    // Expected outputs after the coming edge, from the inputs now applied.
    task automatic predict();
        int nxt, w;
        if (m_phase == P_SERVE && !bus.seed_req_i && bus.req_i != 0) begin
            w = rr_pick(last_win, bus.req_i);
            e_gnt = 4'(1 << w); e_valid = 1; e_num = bus.rng_number_i; last_win = w;
        end else begin
            e_gnt = '0; e_valid = 0;
        end
        if (m_phase == P_SERVE) begin
            if (run > 0 && bus.rng_number_i == run_word) run++; else run = 1;
            run_word = bus.rng_number_i;
            if (run >= 3 && CHK) e_stuck = 1;
        end else run = 0;
        if (m_phase == P_WARM) begin
            if (warm_left > 1) begin warm_left--; nxt = P_WARM; end
            else nxt = bus.seed_req_i ? P_LOAD : P_SERVE;
        end else if (m_phase == P_SERVE) begin
            nxt = bus.seed_req_i ? P_LOAD : P_SERVE;
        end else begin
            nxt = P_WARM; warm_left = WARMUP;
        end
        e_ack = (nxt == P_LOAD); e_load = (nxt == P_LOAD);
        if (nxt == P_LOAD) begin e_seed = bus.seed_i; e_stuck = 0; end
        e_busy = (nxt != P_SERVE);
        m_phase = nxt;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".gnt"},   32'(bus.gnt_o),          32'(e_gnt));
        chk({tag, ".valid"}, 32'(bus.valid_o),        32'(e_valid));
        chk({tag, ".num"},   bus.number_o,            e_num);
        chk({tag, ".ack"},   32'(bus.seed_ack_o),     32'(e_ack));
        chk({tag, ".load"},  32'(bus.rng_loadseed_o), 32'(e_load));
        chk({tag, ".seed"},  bus.rng_seed_o,          e_seed);
        chk({tag, ".busy"},  32'(bus.busy_o),         32'(e_busy));
        chk({tag, ".stuck"}, 32'(bus.stuck_o),        32'(e_stuck));
    endtask

    task automatic cyc(input string tag);
        predict();
        @(posedge clk);
        #1;
        check_all(tag);
        if (!fix_rng) bus.rng_number_i = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0]  rot [5];
        logic [31:0] prev;
        bit          got;
        rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000; rot[4] = 4'b0001;

        reset = 1'b1;
        bus.seed_req_i = 0; bus.seed_i = '0; bus.req_i = '0; bus.rng_number_i = $urandom;
        #2;
        do_reset();

        // Warm-up with everyone requesting, then strict rotation.
        bus.req_i = 4'hF;
        repeat (WARMUP) cyc("warm");
        for (int i = 0; i < 5; i++) begin
            cyc("rot");
            chk("rot_seq", 32'(bus.gnt_o), 32'(rot[i]));
        end

        for (int i = 0; i < 30; i++) begin
            bus.req_i = 4'($urandom);
            cyc("rand");
        end

        bus.req_i = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            prev = bus.rng_number_i;
            cyc("alt");
            chk("alt_num", bus.number_o, prev);
        end

        // Seed load from SERVE with requests pending.
        bus.req_i = 4'hF; bus.seed_i = 32'h1234_5678; bus.seed_req_i = 1;
        cyc("seed");
        chk("seed_ack", 32'(bus.seed_ack_o), 32'd1);
        chk("seed_val", bus.rng_seed_o, 32'h1234_5678);
        chk("seed_nognt", 32'(bus.gnt_o), 32'd0);
        bus.seed_req_i = 0;
        cyc("post_load");
        chk("ack_pulse", 32'(bus.seed_ack_o), 32'd0);

        // Seed request raised mid warm-up is held until the counter expires.
        repeat (3) cyc("warm2");
        bus.seed_req_i = 1; bus.seed_i = $urandom;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            cyc("pend");
            if (e_ack) got = 1;
        end
        chk("pend_ack_seen", 32'(got), 32'd1);
        bus.seed_req_i = 0;
        repeat (WARMUP + 4) cyc("warm3");

        // Reset asserted while in LOAD.
        bus.seed_req_i = 1;
        cyc("load4");
        bus.seed_req_i = 0;
        #2;
        do_reset();
        chk("rst_load", 32'(bus.rng_loadseed_o), 32'd0);
        chk("rst_ack", 32'(bus.seed_ack_o), 32'd0);
        repeat (WARMUP) cyc("warm4");
        cyc("first");
        chk("first_gnt", 32'(bus.gnt_o), 32'd1);

        // Repeated rng word in SERVE.
        repeat (3) cyc("serve");
        fix_rng = 1; bus.rng_number_i = 32'hDEAD_BEEF;
        repeat (3) cyc("rep");
        fix_rng = 0; bus.rng_number_i = $urandom;
        chk("stuck_set", 32'(bus.stuck_o), 32'(CHK));
        repeat (4) cyc("hold");
        chk("stuck_hold", 32'(bus.stuck_o), 32'(CHK));
        bus.seed_req_i = 1;
        cyc("load5");
        bus.seed_req_i = 0;
        chk("stuck_clr", 32'(bus.stuck_o), 32'd0);
        repeat (WARMUP + 6) cyc("tail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/rng_sched.md
Name: rng_sched

Overview:
- Round-robin scheduler sharing one rng instance among NREQ requesters.
- Sequences rng seeding: issues a one-cycle load pulse, then discards WARMUP outputs before serving.
- Delivers at most one fresh rng word per cycle to exactly one granted requester.
- Sits between the rng core and its consumers.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WARMUP, 8, rng output cycles discarded after reset or seed load (min 2).
- CW, 5, warm-up counter width (must hold WARMUP).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- seed_req_i  input  1  request to reseed the rng; level, held until seed_ack_o.
- seed_i  input  32  seed value; sampled when seed_ack_o is asserted.
- seed_ack_o  output  1  one-cycle pulse; seed accepted.
- rng_loadseed_o  output  1  to rng loadseed_i.
- rng_seed_o  output  32  to rng seed_i.
- rng_number_i  input  32  from rng number_o.
- req_i  input  NREQ  per-requester request levels.
- gnt_o  output  NREQ  one-hot grant, registered.
- valid_o  output  1  number_o valid; equals OR of gnt_o.
- number_o  output  32  delivered random word, registered.
- busy_o  output  1  high in LOAD and WARM.
- stuck_o  output  1  sticky repeat flag; only with RNG_REPEAT_CHK_EN, else tied 0.

Behaviour:
- Reset (async, reset low) forces:
  - state=WARM, cnt=WARMUP-1, rr_ptr=NREQ-1.
  - gnt_o=0, valid_o=0, number_o=0, seed_ack_o=0, rng_loadseed_o=0, rng_seed_o=0, busy_o=1, stuck_o=0.
- Reset mid-operation aborts any load, warm-up or grant immediately; the same values apply.
- FSM states: WARM, SERVE, LOAD.
- WARM:
  - cnt decrements each cycle; no grants.
  - When cnt==0 and seed_req_i=0, go to SERVE next cycle.
  - When cnt==0 and seed_req_i=1, go to LOAD.
  - seed_req_i during warm-up is held pending; it is not acted on until cnt==0.
- SERVE:
  - seed_req_i has priority: if high, go to LOAD; no grant that cycle.
  - Otherwise, if any req_i is set, select the first set bit searching from rr_ptr+1 upward, wrapping modulo NREQ.
  - At the next edge: gnt_o=onehot(sel), number_o=rng_number_i, valid_o=1, rr_ptr=sel.
  - If no req_i is set: gnt_o=0, valid_o=0, number_o holds its last value, rr_ptr unchanged.
- LOAD (one cycle):
  - rng_loadseed_o=1, rng_seed_o=seed_i, seed_ack_o=1 (all registered, asserted the cycle after LOAD entry).
  - Next state: WARM with cnt=WARMUP-1.
  - rng_loadseed_o and seed_ack_o are always single-cycle pulses.
- Grant latency: a request sampled at edge n gives gnt_o/number_o valid during cycle n+1.
  - A requester holding req_i high receives a new word on every cycle it wins.
  - Consumers deassert req_i in the cycle they see gnt_o if they want only one word.
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,...,NREQ-1,0 with no gaps.
- rng_number_i changes every cycle. Each sampled word goes to exactly one requester, so no word is delivered twice.
- Words produced during WARM are never delivered.
- busy_o=1 exactly while state is WARM or LOAD.

Optional Feature:
- Macro: RNG_REPEAT_CHK_EN.
- Defined:
  - Register prev=rng_number_i every cycle in SERVE.
  - If a sampled word equals prev on two consecutive SERVE cycles, set stuck_o=1.
  - stuck_o stays high until reset or the next LOAD.
- Undefined: no prev register; stuck_o is constant 0.

Test Plan:
- Reset with all req_i=1, WARMUP=8 -> busy_o=1 and no gnt_o for 8 cycles after reset release; first grant gnt_o=4'b0001, then 0010, 0100, 1000, 0001.
- req_i=4'b1010 held in SERVE -> gnt_o alternates 0010, 1000; number_o equals rng_number_i of the previous cycle each time.
- seed_req_i=1, seed_i=32'h1234_5678 in SERVE with req_i active -> no grant; next cycle rng_loadseed_o=1, rng_seed_o=32'h12345678, seed_ack_o=1 for exactly one cycle; then 8 grant-free cycles.
- seed_req_i asserted at warm-up cycle 3 -> no LOAD until cnt reaches 0; then LOAD, second warm-up of 8 cycles.
- reset pulsed low during LOAD -> rng_loadseed_o and seed_ack_o drop to 0 immediately; FSM restarts in WARM with rr_ptr=NREQ-1.
- RNG_REPEAT_CHK_EN defined, rng_number_i forced to 32'hDEADBEEF for 3 SERVE cycles -> stuck_o=1 and stays set; clears after a LOAD. Undefined -> stuck_o=0.
